// File: rtl/uart_tx_arbiter_if.sv
// Bundle of source FIFO read ports, the downstream FIFO-style port and arbiter status.
// The master modport is the arbiter side; the slave modport is the sources/sequencer side.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned GW    = 2
);
    logic [N_SRC-1:0]   src_empty;
    logic [8*N_SRC-1:0] src_data;
    logic [N_SRC-1:0]   src_read;
    logic               empty;
    logic [7:0]         data;
    logic               read;
    logic [GW-1:0]      grant;
    logic               busy;

    modport master (
        input  src_empty, src_data, read,
        output src_read, empty, data, grant, busy
    );

    modport slave (
        output src_empty, src_data, read,
        input  src_read, empty, data, grant, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with a per-grant burst limit, feeding one byte at a time from
// N_SRC source FIFOs into a holding register that looks like a single FIFO downstream.
module uart_tx_arbiter #(
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned GW        = 2,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_tx_arbiter_if.master     if_arb
);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_HOLD, S_POST} state_t;

    state_t           r_state, w_state_nxt;
    logic [BW-1:0]    r_burst_cnt, w_burst_nxt;
    logic             r_owned, w_owned_nxt;
    logic [GW-1:0]    r_grant, w_grant_nxt;
    logic [N_SRC-1:0] r_src_read, w_src_read_nxt;
    logic             r_empty, w_empty_nxt;
    logic [7:0]       r_data, w_data_nxt;
    logic             r_busy, w_busy_nxt;

    logic             w_keep;
    logic             w_sel_valid;
    logic [GW-1:0]    w_sel_idx;
    logic [GW-1:0]    w_idx;
    int unsigned      w_start;
    logic [7:0]       w_bytes [N_SRC];

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_bytes
        assign w_bytes[gi] = if_arb.src_data[8*gi +: 8];
    end

    // Keep the current owner if it still has data and budget, else round-robin search.
    always_comb begin
        w_keep      = r_owned && !if_arb.src_empty[r_grant] && (r_burst_cnt < BW'(MAX_BURST));
        w_sel_valid = 1'b0;
        w_sel_idx   = r_grant;
        w_idx       = r_grant;
        w_start     = r_owned ? ((32'(r_grant) + 32'd1) % N_SRC) : 32'(r_grant);
        for (int unsigned k = 0; k < N_SRC; k++) begin
            w_idx = GW'((w_start + k) % N_SRC);
            if (!w_sel_valid && !if_arb.src_empty[w_idx]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_keep || w_sel_valid) w_state_nxt = S_READ;
            S_READ:    w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_HOLD;
            S_HOLD:    if (if_arb.read) w_state_nxt = S_POST;
            S_POST:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and arbitration bookkeeping.
    always_comb begin
        w_burst_nxt    = r_burst_cnt;
        w_owned_nxt    = r_owned;
        w_grant_nxt    = r_grant;
        w_src_read_nxt = '0;
        w_empty_nxt    = r_empty;
        w_data_nxt     = r_data;
        w_busy_nxt     = (w_state_nxt != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_keep) begin
                    w_src_read_nxt = N_SRC'(1) << r_grant;
                end else if (w_sel_valid) begin
                    w_grant_nxt    = w_sel_idx;
                    w_burst_nxt    = '0;
                    w_owned_nxt    = 1'b1;
                    w_src_read_nxt = N_SRC'(1) << w_sel_idx;
                end else begin
                    w_owned_nxt    = 1'b0;
                end
            end
            S_CAPTURE: begin
                w_data_nxt  = w_bytes[r_grant];
                w_empty_nxt = 1'b0;
                w_burst_nxt = BW'(r_burst_cnt + 1'b1);
            end
            S_HOLD: begin
                if (if_arb.read) w_empty_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_cnt <= '0;
            r_owned     <= 1'b0;
            r_grant     <= '0;
            r_src_read  <= '0;
            r_empty     <= 1'b1;
            r_data      <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_burst_cnt <= w_burst_nxt;
            r_owned     <= w_owned_nxt;
            r_grant     <= w_grant_nxt;
            r_src_read  <= w_src_read_nxt;
            r_empty     <= w_empty_nxt;
            r_data      <= w_data_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign if_arb.src_read = r_src_read;
    assign if_arb.empty    = r_empty;
    assign if_arb.data     = r_data;
    assign if_arb.grant    = r_grant;
    assign if_arb.busy     = r_busy;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with MAX_BURST=4, one with MAX_BURST=1.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_SRC(4), .GW(2)) bus0 ();
    uart_tx_arbiter_if #(.N_SRC(4), .GW(2)) bus1 ();

    uart_tx_arbiter #(.N_SRC(4), .GW(2), .MAX_BURST(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .if_arb(bus0));
    uart_tx_arbiter #(.N_SRC(4), .GW(2), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .if_arb(bus1));

    // Fixed per-source bytes: src0=11, src1=22, src2=A5, src3=44
    localparam logic [31:0] SRC_BYTES = 32'h44A52211;

    int n_pass  = 0;
    int n_total = 0;
    int pulses0 = 0;
    int bad1    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one cycle and sample 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        pulses0 += $countones(bus0.src_read);
        if (bus1.src_read[0] || bus1.src_read[2]) bad1++;
    endtask

    task automatic wait_byte(input int which, input string tag);
        int n = 0;
        logic e;
        e = (which == 0) ? bus0.empty : bus1.empty;
        while (e !== 1'b0 && n < 12) begin
            step();
            n++;
            e = (which == 0) ? bus0.empty : bus1.empty;
        end
        chk(tag, 32'(e), 32'd0);
    endtask

    task automatic consume(input int which);
        if (which == 0) bus0.read = 1'b1; else bus1.read = 1'b1;
        step();
        bus0.read = 1'b0;
        bus1.read = 1'b0;
    endtask

    initial begin
        int exp_g [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        int exp_g1 [4] = '{1, 3, 1, 3};
        logic [7:0] held;
        int unstable;
        int not_empty_low;

        rst_n          = 1'b0;
        bus0.src_empty = 4'hF;
        bus1.src_empty = 4'hF;
        bus0.src_data  = SRC_BYTES;
        bus1.src_data  = SRC_BYTES;
        bus0.read      = 1'b0;
        bus1.read      = 1'b0;
        step();
        step();
        chk("rst_src_read", 32'(bus0.src_read), 32'h0);
        chk("rst_empty",    32'(bus0.empty),    32'h1);
        chk("rst_data",     32'(bus0.data),     32'h0);
        chk("rst_grant",    32'(bus0.grant),    32'h0);
        chk("rst_busy",     32'(bus0.busy),     32'h0);
        rst_n = 1'b1;
        step();
        step();

        // Single byte from source 2; source goes empty right after its strobe
        bus0.src_empty = 4'b1011;
        step();
        chk("single_src_read", 32'(bus0.src_read), 32'h4);
        chk("single_busy",     32'(bus0.busy),     32'h1);
        bus0.src_empty = 4'hF;
        step();
        chk("single_src_read_off", 32'(bus0.src_read), 32'h0);
        chk("single_empty_cap",    32'(bus0.empty),    32'h1);
        step();
        chk("single_empty_low", 32'(bus0.empty), 32'h0);
        chk("single_data",      32'(bus0.data),  32'hA5);
        chk("single_grant",     32'(bus0.grant), 32'h2);
        step();
        step();
        chk("single_hold_empty", 32'(bus0.empty), 32'h0);
        consume(0);
        chk("single_post_empty", 32'(bus0.empty), 32'h1);
        chk("single_post_data",  32'(bus0.data),  32'hA5);
        step();
        chk("single_idle_busy", 32'(bus0.busy), 32'h0);
        chk("single_idle_data", 32'(bus0.data), 32'hA5);

        // Burst limit 4 between sources 0 and 1
        bus0.src_empty = 4'b1100;
        for (int i = 0; i < 9; i++) begin
            wait_byte(0, $sformatf("burst_wait%0d", i));
            chk($sformatf("burst_grant%0d", i), 32'(bus0.grant), 32'(exp_g[i]));
            chk($sformatf("burst_data%0d", i), 32'(bus0.data),
                32'((SRC_BYTES >> (8 * exp_g[i])) & 32'hFF));
            consume(0);
        end

        // Back-pressure: all sources ready, no reads for 50 cycles
        bus0.src_empty = 4'h0;
        pulses0 = 0;
        wait_byte(0, "bp_wait");
        held = bus0.data;
        unstable = 0;
        not_empty_low = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bus0.data !== held) unstable++;
            if (bus0.empty !== 1'b0) not_empty_low++;
        end
        chk("bp_pulses",   32'(pulses0),       32'd1);
        chk("bp_grant",    32'(bus0.grant),    32'h0);
        chk("bp_data",     32'(held),          32'h11);
        chk("bp_unstable", 32'(unstable),      32'd0);
        chk("bp_empty",    32'(not_empty_low), 32'd0);

        // Reset while holding a byte, then restart with sources 2 and 3 ready
        #2;
        rst_n = 1'b0;
        #1;
        chk("hrst_empty",    32'(bus0.empty),    32'h1);
        chk("hrst_data",     32'(bus0.data),     32'h0);
        chk("hrst_src_read", 32'(bus0.src_read), 32'h0);
        chk("hrst_busy",     32'(bus0.busy),     32'h0);
        bus0.src_empty = 4'b0011;
        step();
        step();
        rst_n = 1'b1;
        wait_byte(0, "hrst_wait");
        chk("hrst_grant", 32'(bus0.grant), 32'h2);
        chk("hrst_data2", 32'(bus0.data),  32'hA5);
        bus0.src_empty = 4'hF;
        consume(0);
        step();
        step();

        // Spurious read while idle and all sources empty
        pulses0 = 0;
        bus0.read = 1'b1;
        step();
        step();
        step();
        bus0.read = 1'b0;
        chk("spur_empty",  32'(bus0.empty), 32'h1);
        chk("spur_busy",   32'(bus0.busy),  32'h0);
        chk("spur_pulses", 32'(pulses0),    32'd0);
        chk("spur_data",   32'(bus0.data),  32'hA5);

        // Skip empty sources with MAX_BURST=1: only 1 and 3 ready
        bad1 = 0;
        bus1.src_empty = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            wait_byte(1, $sformatf("skip_wait%0d", i));
            chk($sformatf("skip_grant%0d", i), 32'(bus1.grant), 32'(exp_g1[i]));
            chk($sformatf("skip_data%0d", i), 32'(bus1.data),
                32'((SRC_BYTES >> (8 * exp_g1[i])) & 32'hFF));
            consume(1);
        end
        bus1.src_empty = 4'hF;
        step();
        chk("skip_bad_reads", 32'(bad1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit path among N_SRC byte sources. Each source is a FIFO read port: empty, data, read.
- Selects a source using round-robin with a per-grant burst limit and fetches one byte at a time into a holding register.
- Presents that byte downstream as a single FIFO-style port (empty/data/read), which the transmit sequencer consumes unchanged.
- Sits between the per-client TX FIFOs and the UART transmit sequencer.

Parameters:
- N_SRC, 4, number of requesting sources (2..8).
- GW, 2, width of the grant index; 2**GW >= N_SRC.
- MAX_BURST, 16, maximum bytes taken from one source per grant (>=1).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- src_empty  input  N_SRC  bit i high = source i FIFO empty.
- src_data  input  8*N_SRC  source i byte on [8*i+7:8*i]; valid the cycle after src_read[i] pulses.
- src_read  output  N_SRC  one-cycle read strobe to source i; registered.
- empty  output  1  low = holding register has a byte for downstream.
- data  output  8  holding register byte.
- read  input  1  downstream consume strobe.
- grant  output  GW  index of the current/last granted source.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, rst_n low) applies the following values:
  - Outputs: src_read=0, empty=1, data=0, grant=0, busy=0.
  - Internal: state=IDLE, burst_cnt=0, owned=0.
- Registers: burst_cnt has width clog2(MAX_BURST+1). owned flag = grant currently holds a burst.
- States: IDLE, READ, CAPTURE, HOLD, POST.
- IDLE: evaluates src_empty each cycle.
  - Keep grant if owned=1, src_empty[grant]=0 and burst_cnt<MAX_BURST.
  - Otherwise search round-robin for the first non-empty source, starting at (owned ? grant+1 : grant) modulo N_SRC. On a hit: grant<=hit, burst_cnt<=0, owned<=1.
  - If no source is non-empty: owned<=0, stay in IDLE.
  - If a source is selected: go to READ.
- READ (1 cycle): src_read[grant]=1; all other src_read bits 0. Next state CAPTURE.
- CAPTURE (1 cycle): data<=src_data[grant], empty<=0, burst_cnt<=burst_cnt+1. Next state HOLD.
- HOLD: empty=0 and data stable. On read=1: empty<=1, go to POST.
- POST (1 cycle): data remains unchanged, so the downstream can latch the byte the cycle after its read strobe. Next state IDLE.
- Latency:
  - Source becomes non-empty, sampled in IDLE at cycle T: src_read high at T+1, empty low at T+3.
  - read at cycle R: empty high at R+1; next src_read no earlier than R+3.
- data changes only in CAPTURE; it holds its value across IDLE/POST.
- At most one src_read bit is high in any cycle. There is never a second read to a source before its previous byte is captured.
- read while empty=1 (any state other than HOLD) is ignored.
- A source going empty after its READ strobe has no effect; the byte is still captured.
- burst_cnt reaching MAX_BURST forces rotation at the next IDLE if any other source is non-empty.
  - If only the same source is non-empty, the search wraps to it: it is re-granted and burst_cnt resets to 0.
- Sources that are empty are skipped. Fairness: with all sources busy, each gets MAX_BURST bytes in index order.
- Reset asserted mid-transfer (any state) returns all outputs to reset values immediately. A pending held byte is discarded.

Test Plan:
- Single byte. Reset, then src_empty=4'b1011, source 2 returns 8'hA5 on the cycle after src_read[2].
  - Required: src_read=4'b0100 for exactly 1 cycle; empty low 2 cycles later with data=8'hA5 and grant=2.
  - Required: after read, empty high at the next cycle and data still 8'hA5.
- Burst limit. MAX_BURST=4, sources 0 and 1 both always non-empty.
  - Required: grant sequence 0,0,0,0,1,1,1,1,0…; each byte is separated by a read.
- Skip empty. Only sources 1 and 3 non-empty, MAX_BURST=1.
  - Required: grants alternate 1,3,1,3; src_read[0] and src_read[2] never asserted.
- Back-pressure. Hold read low for 50 cycles while all sources are non-empty.
  - Required: exactly one src_read pulse; data stable; empty=0 throughout.
- Reset in HOLD. Assert rst_n low while empty=0.
  - Required: empty=1, data=0, src_read=0 immediately.
  - Required: after release, the first grant goes to the lowest-index non-empty source.
- Spurious read. Pulse read while in IDLE with all sources empty.
  - Required: no state change; empty stays 1; busy stays 0.
